// File: rtl/brent_kung_sub_pipe_if.sv
// Valid/ready stream bundle for brent_kung_sub_pipe: operand pair in, {borrow, difference} out.
// The ovf wire exists only when SUB_OVF_EN is defined.
interface brent_kung_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   d;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  d
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output d
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage Brent-Kung prefix subtractor, d = {borrow, a - b}, computed as a + ~b + 1.
// Optional feature macro SUB_OVF_EN adds a signed-overflow flag pipelined alongside d.
module brent_kung_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  brent_kung_sub_pipe_if.slave bus
);
  localparam int LOG_W = $clog2(WIDTH);

  logic adv;

  // Stage 1: per-bit generate/propagate
  logic [WIDTH-1:0] g_next;
  logic [WIDTH-1:0] gp_next;
  logic [WIDTH-1:0] p_next;
  logic             v1_reg;
  logic [WIDTH-1:0] g1_reg;
  logic [WIDTH-1:0] gp1_reg;
  logic [WIDTH-1:0] p1_reg;

  // Stage 2: up-sweep results
  logic             v2_reg;
  logic [WIDTH-1:0] g2_reg;
  logic [WIDTH-1:0] gp2_reg;
  logic [WIDTH-1:0] p2_reg;

  // Stage 3: sum and borrow
  logic             v3_reg;
  logic [WIDTH-1:0] pre_g;
  logic [WIDTH-1:0] carry;
  logic [WIDTH:0]   d_next;
  logic [WIDTH:0]   d_reg;

`ifdef SUB_OVF_EN
  logic a_msb1_reg;
  logic b_msb1_reg;
  logic a_msb2_reg;
  logic b_msb2_reg;
  logic ovf_next;
  logic ovf_reg;
`endif

  assign adv           = ~v3_reg | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_reg;
  assign bus.d         = d_reg;

  genvar gi, gj;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign p_next[gi] = bus.a[gi] ^ ~bus.b[gi];
      if (gi == 0) begin : g_cin
        // The fixed carry-in of 1 is folded into bit 0, so the tree needs no separate cin term.
        assign g_next[gi]  = (bus.a[gi] & ~bus.b[gi]) | (bus.a[gi] ^ ~bus.b[gi]);
        assign gp_next[gi] = 1'b0;
      end else begin : g_plain
        assign g_next[gi]  = bus.a[gi] & ~bus.b[gi];
        assign gp_next[gi] = bus.a[gi] ^ ~bus.b[gi];
      end
    end
  endgenerate

  // Up-sweep: after level gi, node j with (j+1) divisible by 2^gi spans 2^gi bits.
  generate
    for (gi = 0; gi <= LOG_W; gi++) begin : up
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      if (gi == 0) begin : g_base
        assign g = g1_reg;
        assign p = gp1_reg;
      end else begin : g_lvl
        for (gj = 0; gj < WIDTH; gj++) begin : node
          if (((gj + 1) % (1 << gi)) == 0) begin : g_comb
            assign g[gj] = up[gi-1].g[gj] | (up[gi-1].p[gj] & up[gi-1].g[gj - (1 << (gi - 1))]);
            assign p[gj] = up[gi-1].p[gj] & up[gi-1].p[gj - (1 << (gi - 1))];
          end else begin : g_pass
            assign g[gj] = up[gi-1].g[gj];
            assign p[gj] = up[gi-1].p[gj];
          end
        end
      end
    end
  endgenerate

  // Down-sweep: step gi fills the nodes halfway between the prefixes known at level LOG_W-gi.
  generate
    for (gi = 0; gi < LOG_W; gi++) begin : dn
      logic [WIDTH-1:0] g;
      if (gi == 0) begin : g_base
        assign g = g2_reg;
      end else begin : g_lvl
        localparam int FULL = 1 << (LOG_W - gi);
        localparam int HALF = FULL / 2;
        for (gj = 0; gj < WIDTH; gj++) begin : node
          if ((gj >= FULL) && (((gj + 1) % FULL) == HALF)) begin : g_comb
            assign g[gj] = dn[gi-1].g[gj] | (gp2_reg[gj] & dn[gi-1].g[gj - HALF]);
          end else begin : g_pass
            assign g[gj] = dn[gi-1].g[gj];
          end
        end
      end
    end
  endgenerate

  assign pre_g  = dn[LOG_W-1].g;
  assign carry  = {pre_g[WIDTH-2:0], 1'b1};
  assign d_next = {~pre_g[WIDTH-1], p2_reg ^ carry};

  // Group-propagate bits that no down-sweep node reads are gathered here to keep the sweep regular.
  logic unused_gp;
  assign unused_gp = ^gp2_reg;

`ifdef SUB_OVF_EN
  assign ovf_next = (a_msb2_reg ^ b_msb2_reg) & (a_msb2_reg ^ d_next[WIDTH-1]);
  assign bus.ovf  = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      g1_reg     <= '0;
      gp1_reg    <= '0;
      p1_reg     <= '0;
      v2_reg     <= 1'b0;
      g2_reg     <= '0;
      gp2_reg    <= '0;
      p2_reg     <= '0;
      v3_reg     <= 1'b0;
      d_reg      <= '0;
`ifdef SUB_OVF_EN
      a_msb1_reg <= 1'b0;
      b_msb1_reg <= 1'b0;
      a_msb2_reg <= 1'b0;
      b_msb2_reg <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else if (adv) begin
      // Whole pipe shifts together; bubbles travel as cleared valid bits.
      v1_reg     <= bus.in_valid;
      g1_reg     <= g_next;
      gp1_reg    <= gp_next;
      p1_reg     <= p_next;
      v2_reg     <= v1_reg;
      g2_reg     <= up[LOG_W].g;
      gp2_reg    <= up[LOG_W].p;
      p2_reg     <= p1_reg;
      v3_reg     <= v2_reg;
      d_reg      <= d_next;
`ifdef SUB_OVF_EN
      a_msb1_reg <= bus.a[WIDTH-1];
      b_msb1_reg <= bus.b[WIDTH-1];
      a_msb2_reg <= a_msb1_reg;
      b_msb2_reg <= b_msb1_reg;
      ovf_reg    <= ovf_next;
`endif
    end
  end
endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Directed-vector bench for brent_kung_sub_pipe (WIDTH = 8): latency, borrow, stall, reset, random stream.
// Overflow checks are active when SUB_OVF_EN is defined.
module tb_brent_kung_sub_pipe;
  localparam int WIDTH = 8;
  localparam int N_VEC = 10;
  localparam int N_RND = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  brent_kung_sub_pipe_if #(.WIDTH(WIDTH)) bus();

  brent_kung_sub_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] d;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [8:0] d;
    logic       ovf;
  } exp_t;

  vec_t       vecs[N_VEC];
  exp_t       sb[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] bp_exp[4];
  int         got;
  logic       accept;
  int         sent;
  int         cyc;
  logic       stalled;
  logic [8:0] held_d;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] d, input logic ovf);
    vecs[i].name = name;
    vecs[i].a    = a;
    vecs[i].b    = b;
    vecs[i].d    = d;
    vecs[i].ovf  = ovf;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    set_vec(0, "basic_05_03",  8'h05, 8'h03, 9'h002, 1'b0);
    set_vec(1, "borrow_03_05", 8'h03, 8'h05, 9'h1FE, 1'b0);
    set_vec(2, "ext_00_FF",    8'h00, 8'hFF, 9'h101, 1'b0);
    set_vec(3, "eq_FF_FF",     8'hFF, 8'hFF, 9'h000, 1'b0);
    set_vec(4, "ovf_80_01",    8'h80, 8'h01, 9'h07F, 1'b1);
    set_vec(5, "noovf_7F_01",  8'h7F, 8'h01, 9'h07E, 1'b0);
    set_vec(6, "max_FF_00",    8'hFF, 8'h00, 9'h0FF, 1'b0);
    set_vec(7, "wrap_00_01",   8'h00, 8'h01, 9'h1FF, 1'b0);
    set_vec(8, "ovf_7F_80",    8'h7F, 8'h80, 9'h1FF, 1'b1);
    set_vec(9, "small_10_01",  8'h10, 8'h01, 9'h00F, 1'b0);

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state, with out_ready low so in_ready can only be high because the pipe is empty
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("rst_d", 16'(bus.d), 16'h0);
`ifdef SUB_OVF_EN
    check("rst_ovf", 16'(bus.ovf), 16'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 16'(bus.in_ready), 16'h1);
    check("post_rst_out_valid", 16'(bus.out_valid), 16'h0);

    // Table: inputs driven just after edge N, result must be visible just after edge N+3
    bus.out_ready = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({vecs[i].name, "_lat1"}, 16'(bus.out_valid), 16'h0);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_lat2"}, 16'(bus.out_valid), 16'h0);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_valid"}, 16'(bus.out_valid), 16'h1);
      check({vecs[i].name, "_d"}, 16'(bus.d), 16'(vecs[i].d));
`ifdef SUB_OVF_EN
      check({vecs[i].name, "_ovf"}, 16'(bus.ovf), 16'(vecs[i].ovf));
`endif
    end

    // Backpressure: four beats, stall 5 cycles once out_valid rises, then drain in order
    bp_exp[0] = 9'h00F;
    bp_exp[1] = 9'h01E;
    bp_exp[2] = 9'h02D;
    bp_exp[3] = 9'h03C;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(8'((k + 1) * 16), 8'(k + 1));
      @(posedge clk);
      #1;
    end
    check("bp_rise", 16'(bus.out_valid), 16'h1);
    drive(8'h40, 8'h04);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_stall_in_ready", 16'(bus.in_ready), 16'h0);
      check("bp_stall_valid", 16'(bus.out_valid), 16'h1);
      check("bp_stall_d", 16'(bus.d), 16'h00F);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #1;
      accept = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_out%0d", got), 16'(bus.d), 16'(bp_exp[got]));
        got++;
      end
      @(posedge clk);
      #1;
      if (accept) bus.in_valid = 1'b0;
    end
    check("bp_count", 16'(got), 16'd4);
    check("bp_no_dup", 16'(bus.out_valid), 16'h0);

    // Reset with three beats in flight: nothing may emerge afterwards
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive(8'h11 + 8'(k), 8'h01);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_out_valid", 16'(bus.out_valid), 16'h0);
    check("mrst_d", 16'(bus.d), 16'h0);
    check("mrst_in_ready", 16'(bus.in_ready), 16'h1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("mrst_flush%0d", k), 16'(bus.out_valid), 16'h0);
    end

    // Random stream against a scoreboard, random bubbles and backpressure
    sent = 0;
    cyc = 0;
    stalled = 1'b0;
    held_d = '0;
    sb.delete();
    while ((sent < N_RND || sb.size() > 0) && cyc < 5000) begin
      bus.in_valid  = (sent < N_RND) && ($urandom_range(0, 3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) check("rnd_hold_d", 16'(bus.d), 16'(held_d));
      if (bus.in_valid && bus.in_ready) begin
        e.d   = {1'b0, bus.a} - {1'b0, bus.b};
        e.ovf = (bus.a[7] ^ bus.b[7]) & (bus.a[7] ^ e.d[7]);
        sb.push_back(e);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", 16'(bus.out_valid), 16'h0);
        end else begin
          e = sb.pop_front();
          check("rnd_d", 16'(bus.d), 16'(e.d));
`ifdef SUB_OVF_EN
          check("rnd_ovf", 16'(bus.ovf), 16'(e.ovf));
`endif
        end
      end
      stalled = bus.out_valid & ~bus.out_ready;
      held_d  = bus.d;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rnd_all_sent", 16'(sent), 16'(N_RND));
    check("rnd_drained", 16'(sb.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
